// File: rtl/mem_pkg.sv
// Shared encodings for the memory pipeline stage: access sizes, exception codes,
// FSM state constants and a lane-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_BUSY  = 2'b01;
  localparam state_t ST_DRAIN = 2'b10;

  // Number of byte lanes on a data bus of the given width.
  function automatic int unsigned lane_count(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a DATA_W-wide bus: store byte enables and replication,
// load lane extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] off,
  input  logic [1:0]                  size,
  input  logic                        is_unsigned,
  input  logic [DATA_W-1:0]           store_data,
  input  logic [DATA_W-1:0]           load_raw,
  output logic [DATA_W/8-1:0]         be_c,
  output logic [DATA_W-1:0]           wdata_c,
  output logic [DATA_W-1:0]           load_data_c
);

  localparam int unsigned NB = lane_count(DATA_W);

  logic [NB-1:0]     size_mask;
  logic [DATA_W-1:0] shifted;
  logic              sign_bit;
  int unsigned       ext_w;

  // Store side: lane mask shifted into place, data replicated across all lanes.
  always_comb begin
    size_mask = '0;
    wdata_c   = store_data;
    case (size)
      SZ_BYTE: begin
        size_mask = NB'(8'h01);
        wdata_c   = {NB{store_data[7:0]}};
      end
      SZ_HALF: begin
        size_mask = NB'(8'h03);
        wdata_c   = {(NB/2){store_data[15:0]}};
      end
      SZ_WORD: begin
        size_mask = NB'(8'h0F);
        wdata_c   = {(NB/4){store_data[31:0]}};
      end
      default: begin
        size_mask = NB'(8'hFF);
        wdata_c   = store_data;
      end
    endcase
    be_c = size_mask << off;
  end

  // Load side: bring the addressed lane down to bit 0, then extend above the access width.
  always_comb begin
    shifted  = load_raw >> {off, 3'b000};
    ext_w    = DATA_W;
    sign_bit = shifted[DATA_W-1];
    case (size)
      SZ_BYTE: begin
        ext_w    = 8;
        sign_bit = shifted[7];
      end
      SZ_HALF: begin
        ext_w    = 16;
        sign_bit = shifted[15];
      end
      SZ_WORD: begin
        ext_w    = 32;
        sign_bit = shifted[31];
      end
      default: begin
        ext_w    = DATA_W;
        sign_bit = shifted[DATA_W-1];
      end
    endcase
    load_data_c = shifted;
    for (int unsigned b = 0; b < DATA_W; b++) begin
      if (b >= ext_w) load_data_c[b] = sign_bit & ~is_unsigned;
    end
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with a req/ack data-memory port: issues accesses, stalls
// upstream while one is outstanding, and registers the MEM/WB fields.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_write_data,
  input  logic [ADDR_W-1:0]     in_pc_plus4,
  input  logic [1:0]            in_memtoreg,
  input  logic                  in_regwrite,
  input  logic [REG_W-1:0]      in_write_reg,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall_out,
  output logic                  wb_valid,
  output logic [ADDR_W-1:0]     wb_alu_result,
  output logic [DATA_W-1:0]     wb_read_data,
  output logic [1:0]            wb_memtoreg,
  output logic                  wb_regwrite,
  output logic [REG_W-1:0]      wb_write_reg,
  output logic [ADDR_W-1:0]     wb_pc_plus4,
  output logic [1:0]            wb_exc
);

  localparam int unsigned NB    = lane_count(DATA_W);
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  localparam logic [1:0] WB_BUBBLE   = 2'd0;
  localparam logic [1:0] WB_RESULT   = 2'd1;
  localparam logic [1:0] WB_MISALIGN = 2'd2;
  localparam logic [1:0] WB_TIMEOUT  = 2'd3;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OFF_W-1:0]  off;
  logic              memop, is_store, is_load, misaligned, issue, timed_out;
  logic [ADDR_W-1:0] addr_aligned;
  logic [NB-1:0]     be_c;
  logic [DATA_W-1:0] wdata_c, load_data_c;

  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NB-1:0]     req_be;

  logic              wb_load;
  logic [1:0]        wb_sel;
  logic              n_valid, n_regwrite;
  logic [ADDR_W-1:0] n_alu, n_pc;
  logic [DATA_W-1:0] n_rdata;
  logic [1:0]        n_memtoreg, n_exc;
  logic [REG_W-1:0]  n_reg;

  assign memop        = in_valid & (in_mem_read | in_mem_write);
  assign is_store     = in_mem_write;
  assign is_load      = in_mem_read & ~in_mem_write;
  assign off          = in_alu_result[OFF_W-1:0];
  assign addr_aligned = in_alu_result & ~ADDR_W'(NB - 1);

  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      SZ_HALF:  misaligned = off[0];
      SZ_WORD:  misaligned = |off[1:0];
      SZ_DWORD: misaligned = (|off) | (DATA_W == 32);
      default:  misaligned = 1'b0;
    endcase
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .off         (off),
    .size        (in_size),
    .is_unsigned (in_unsigned),
    .store_data  (in_write_data),
    .load_raw    (mem_rdata),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .load_data_c (load_data_c)
  );

  // Bus side: live from the instruction in IDLE, frozen copy while the access is outstanding.
  assign issue     = (state == ST_IDLE) & memop & ~misaligned & ~flush;
  assign timed_out = (cnt >= CNT_LIMIT);
  assign mem_req   = issue | (state != ST_IDLE);
  assign mem_we    = (state == ST_IDLE) ? is_store     : req_we;
  assign mem_addr  = (state == ST_IDLE) ? addr_aligned : req_addr;
  assign mem_wdata = (state == ST_IDLE) ? wdata_c      : req_wdata;
  assign mem_be    = (state == ST_IDLE) ? be_c         : req_be;
  assign stall_out = (state == ST_IDLE) ? (issue & ~mem_ack) : (~mem_ack & ~timed_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_be    <= '0;
    end else if (issue) begin
      req_we    <= is_store;
      req_addr  <= addr_aligned;
      req_wdata <= wdata_c;
      req_be    <= be_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, timeout counter and which record (if any) MEM/WB takes this cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wb_load   = 1'b0;
    wb_sel    = WB_BUBBLE;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (flush | ~in_valid) begin
          wb_load = 1'b1;
          wb_sel  = WB_BUBBLE;
        end else if (!memop) begin
          wb_load = 1'b1;
          wb_sel  = WB_RESULT;
        end else if (misaligned) begin
          wb_load = 1'b1;
          wb_sel  = WB_MISALIGN;
        end else if (mem_ack) begin
          wb_load = 1'b1;
          wb_sel  = WB_RESULT;
        end else begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_BUSY, ST_DRAIN: begin
        if (mem_ack | timed_out) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          wb_load   = 1'b1;
          if ((state == ST_DRAIN) | flush) wb_sel = WB_BUBBLE;
          else if (mem_ack)                wb_sel = WB_RESULT;
          else                             wb_sel = WB_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (flush) state_nxt = ST_DRAIN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    n_valid    = 1'b0;
    n_alu      = '0;
    n_rdata    = '0;
    n_memtoreg = '0;
    n_regwrite = 1'b0;
    n_reg      = '0;
    n_pc       = '0;
    n_exc      = EXC_NONE;
    if (wb_sel != WB_BUBBLE) begin
      n_valid    = 1'b1;
      n_alu      = in_alu_result;
      n_memtoreg = in_memtoreg;
      n_reg      = in_write_reg;
      n_pc       = in_pc_plus4;
    end
    case (wb_sel)
      WB_RESULT: begin
        n_regwrite = in_regwrite;
        n_rdata    = is_load ? load_data_c : '0;
      end
      WB_MISALIGN: n_exc = EXC_MISALIGN;
      WB_TIMEOUT:  n_exc = EXC_TIMEOUT;
      default:     n_exc = EXC_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_memtoreg   <= '0;
      wb_regwrite   <= 1'b0;
      wb_write_reg  <= '0;
      wb_pc_plus4   <= '0;
      wb_exc        <= EXC_NONE;
    end else if (wb_load) begin
      wb_valid      <= n_valid;
      wb_alu_result <= n_alu;
      wb_read_data  <= n_rdata;
      wb_memtoreg   <= n_memtoreg;
      wb_regwrite   <= n_regwrite;
      wb_write_reg  <= n_reg;
      wb_pc_plus4   <= n_pc;
      wb_exc        <= n_exc;
    end
  end

endmodule
